instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch front end feeding the control decoder. An Avalon-MM read master that
//  fetches 32-bit instruction words at the PC, holds each word in a register, and presents
//  its decoded fields (opcode, function_code, b_code, ...) to control and datapath under a
//  valid/ready handshake. Accepts PC redirects from the branch/jump logic and flushes in-flight reads.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  PC loaded on reset; address of first fetch
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset          in   1   synchronous, active-low reset
//  address        out  32  Avalon word address (byte address, [1:0]=0)
//  read           out  1   Avalon read request
//  waitrequest    in   1   Avalon stall; request accepted when read & !waitrequest
//  readdata       in   32  instruction word, valid the cycle after acceptance
//  instr_valid    out  1   held instruction available to decode
//  instr_ready    in   1   core consumes instruction when instr_valid & instr_ready
//  redirect_valid in   1   one-cycle pulse: next fetch from redirect_pc
//  redirect_pc    in   32  target PC for redirect
//  pc_out         out  32  PC of held instruction (for link / pc+4 generation)
//  opcode         out  6   instr[31:26];  function_code out 6 instr[5:0];  b_code out 5 instr[20:16]
//  rs, rt, rd     out  5   instr[25:21], [20:16], [15:11];  shamt out 5 instr[10:6]
//  immediate      out  16  instr[15:0];   jump_target out 26 instr[25:0]
//  misaligned     out  1   one-cycle pulse: redirect_pc[1:0] != 0 was received
//  halted         out  1   fetch stopped (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0 at edge): state=REQ, pc=RESET_VECTOR, instr reg=0, kill=0; outputs: read=0
//    during reset cycle, instr_valid=0, misaligned=0, halted=0, all field outputs 0.
//  - States: REQ -> RESP -> HOLD -> REQ (+ HALT when enabled).
//  - REQ: read=1, address=pc. Stay while waitrequest=1; address and read held stable.
//    On read & !waitrequest -> RESP.
//  - RESP: read=0. Capture readdata into instr reg, pc_out=pc. If kill: discard, clear kill,
//    -> REQ. Else -> HOLD.
//  - HOLD: instr_valid=1. On instr_valid & instr_ready: pc <= pc+4 (mod 2^32, wrap
//    0xFFFFFFFC -> 0), -> REQ. Zero-wait latency: request at cycle N, instr_valid at N+2;
//    sustained throughput one instruction per 3 cycles.
//  - Decoded fields are combinational slices of the instr reg; stable while in HOLD.
//  - Redirect: pc <= {redirect_pc[31:2],2'b00}; misaligned pulses next cycle if [1:0]!=0.
//      REQ (pending/stalled) or RESP: set kill; bus transaction completes normally, data dropped.
//        In REQ, address stays at old pc until accepted (Avalon stability).
//      HOLD with handshake same cycle: instruction consumed, next fetch from redirect_pc.
//      HOLD without handshake: held instruction flushed, instr_valid=0 next cycle, -> REQ.
//      Redirect and pc+4 same cycle: redirect wins. Back-to-back redirects: latest wins.
//  - Branch delay slot is the core's responsibility: it raises redirect no earlier than
//    the handshake of the delay-slot instruction.
//  - Reset mid-transaction: state machine restarts immediately; late readdata ignored.
// CONFIGURATION
//  FETCH_HALT_ON_ZERO_EN defined: when pc would become 0 (via redirect or wrap) the
//    block enters HALT after any in-flight read drains: read=0, instr_valid=0, halted=1;
//    only reset leaves HALT. Redirect to 0 in HOLD with handshake lets that instruction retire.
//  Not defined: halted tied 0; address 0 fetched like any other.
// TESTING
//  1 Reset release, waitrequest=0, readdata=0x8C220004 -> address=0xBFC00000, instr_valid
//    two cycles after read, opcode=35, rs=1, rt=2, immediate=4; with ready=1 next address 0xBFC00004.
//  2 waitrequest=1 for 3 cycles -> read and address held 4 cycles, one instruction delivered.
//  3 instr_ready=0 for 5 cycles -> instr_valid and fields stable, no new read issued.
//  4 redirect_valid, redirect_pc=0x00400010 while REQ stalled -> old read completes, data
//    dropped, next read at 0x00400010, no instr_valid for killed word.
//  5 redirect_pc=0x00400013 -> misaligned pulses 1 cycle, fetch address 0x00400010.
//  6 FETCH_HALT_ON_ZERO_EN: redirect to 0 -> halted=1, read stays 0 for 20 cycles; reset clears.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction-fetch front end. Avalon-MM read master that
//                fetches 32-bit words at the PC, holds each word and presents
//                its decoded fields under a valid/ready handshake. Accepts
//                PC redirects and drops in-flight reads that they overtake.
//                Optional feature macro: FETCH_HALT_ON_ZERO_EN (stop fetching
//                when the PC would become zero).
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic [5:0]  opcode,
    output logic [5:0]  function_code,
    output logic [4:0]  b_code,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] immediate,
    output logic [25:0] jump_target,
    output logic        misaligned,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

`ifdef FETCH_HALT_ON_ZERO_EN
    localparam logic c_halt_en = 1'b1;
`else
    localparam logic c_halt_en = 1'b0;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_redir_pc;
    logic [31:0] w_redir_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_pc_out;
    logic [31:0] w_pc_out_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic        r_misaligned;

    logic [31:0] w_redir_tgt;
    logic [31:0] w_pc_inc;

    // Redirect targets are forced word aligned; the low bits only flag misalignment.
    assign w_redir_tgt = {redirect_pc[31:2], 2'b00};
    assign w_pc_inc    = r_pc + 32'd4;

    // State register plus every piece of fetch state, restarted by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_VECTOR;
            r_redir_pc   <= RESET_VECTOR;
            r_instr      <= 32'd0;
            r_pc_out     <= 32'd0;
            r_kill       <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_kill       <= w_kill_nxt;
            r_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    // Next-state logic. While a request is pending the PC (and so the bus
    // address) is frozen; an overtaking redirect is parked in r_redir_pc and
    // applied once the killed read has drained in RESP.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redir_pc_nxt = r_redir_pc;
        w_instr_nxt    = r_instr;
        w_pc_out_nxt   = r_pc_out;
        w_kill_nxt     = r_kill;
        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    w_kill_nxt     = 1'b1;
                    w_redir_pc_nxt = w_redir_tgt;
                end
                if (!waitrequest) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_instr_nxt  = readdata;
                w_pc_out_nxt = r_pc;
                w_kill_nxt   = 1'b0;
                if (redirect_valid) begin
                    // A redirect arriving now kills this word and wins over a parked one.
                    w_pc_nxt    = w_redir_tgt;
                    w_state_nxt = (c_halt_en && (w_redir_tgt == 32'd0)) ? S_HALT : S_REQ;
                end else if (r_kill) begin
                    w_pc_nxt    = r_redir_pc;
                    w_state_nxt = (c_halt_en && (r_redir_pc == 32'd0)) ? S_HALT : S_REQ;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    // With or without a handshake the next fetch comes from the target.
                    w_pc_nxt    = w_redir_tgt;
                    w_state_nxt = (c_halt_en && (w_redir_tgt == 32'd0)) ? S_HALT : S_REQ;
                end else if (instr_ready) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = (c_halt_en && (w_pc_inc == 32'd0)) ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    assign address     = r_pc;
    assign read        = (r_state == S_REQ) && reset;
    assign instr_valid = (r_state == S_HOLD) && reset;
    assign pc_out      = r_pc_out;
    assign misaligned  = r_misaligned;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign halted = (r_state == S_HALT);
`else
    assign halted = 1'b0;
`endif

    assign opcode        = r_instr[31:26];
    assign rs            = r_instr[25:21];
    assign rt            = r_instr[20:16];
    assign b_code        = r_instr[20:16];
    assign rd            = r_instr[15:11];
    assign shamt         = r_instr[10:6];
    assign function_code = r_instr[5:0];
    assign immediate     = r_instr[15:0];
    assign jump_target   = r_instr[25:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. A small Avalon slave
//                returns words from a fixed memory function; every fetch the
//                stimulus lets through pushes its expected word into a
//                scoreboard that a monitor pops on each handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [5:0]  opcode;
    logic [5:0]  function_code;
    logic [4:0]  b_code;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] immediate;
    logic [25:0] jump_target;
    logic        misaligned;
    logic        halted;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    instr_fetch #(.RESET_VECTOR(32'hBFC00000)) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .read           (read),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_out         (pc_out),
        .opcode         (opcode),
        .function_code  (function_code),
        .b_code         (b_code),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .immediate      (immediate),
        .jump_target    (jump_target),
        .misaligned     (misaligned),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: the reset vector holds lw $2,4($1); elsewhere the
    // word encodes its own address so a wrong fetch address shows up.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h8C220004;
        return {6'h08, 5'd3, 5'd4, a[17:2]};
    endfunction

    // Avalon slave: data appears the cycle after acceptance, garbage otherwise.
    always @(posedge clk) begin
        if (read && !waitrequest) readdata <= mem_word(address);
        else                      readdata <= 32'hDEADBEEF;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Monitor: every consumed instruction must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got instruction at pc 0x%08h expected none", pc_out);
            end else begin
                e = sb.pop_front();
                check("sb_pc_out",   pc_out,            e.pc);
                check("sb_opcode",   32'(opcode),       32'(e.word[31:26]));
                check("sb_rs",       32'(rs),           32'(e.word[25:21]));
                check("sb_rt",       32'(rt),           32'(e.word[20:16]));
                check("sb_b_code",   32'(b_code),       32'(e.word[20:16]));
                check("sb_rd",       32'(rd),           32'(e.word[15:11]));
                check("sb_shamt",    32'(shamt),        32'(e.word[10:6]));
                check("sb_funct",    32'(function_code), 32'(e.word[5:0]));
                check("sb_imm",      32'(immediate),    32'(e.word[15:0]));
                check("sb_jtarget",  32'(jump_target),  32'(e.word[25:0]));
            end
        end
    end

    // Bounded wait for instr_valid, sampled on falling edges.
    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", 32'(instr_valid), 32'd1);
    endtask

    // Expect one instruction from pc, hold it for 'hold' cycles, then consume it.
    task automatic fetch_one(input logic [31:0] pc, input int hold);
        exp_t e;
        e.pc   = pc;
        e.word = mem_word(pc);
        sb.push_back(e);
        wait_valid();
        for (int k = 0; k < hold; k++) begin
            check("hold_valid",  32'(instr_valid), 32'd1);
            check("hold_noread", 32'(read),        32'd0);
            check("hold_imm",    32'(immediate),   32'(e.word[15:0]));
            check("hold_pc",     pc_out,           pc);
            @(negedge clk);
        end
        @(posedge clk); #1 instr_ready = 1'b1;
        @(posedge clk); #1 instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e0;
        reset          = 1'b0;
        waitrequest    = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read",       32'(read),        32'd0);
        check("rst_valid",      32'(instr_valid), 32'd0);
        check("rst_halted",     32'(halted),      32'd0);
        check("rst_misaligned", 32'(misaligned),  32'd0);
        check("rst_opcode",     32'(opcode),      32'd0);
        check("rst_imm",        32'(immediate),   32'd0);
        check("rst_pc_out",     pc_out,           32'd0);

        // 1: first fetch at the reset vector, valid two cycles after read
        @(posedge clk); #1 reset = 1'b1;
        e0.pc   = 32'hBFC00000;
        e0.word = 32'h8C220004;
        sb.push_back(e0);
        @(negedge clk);
        check("t1_read",  32'(read), 32'd1);
        check("t1_addr",  address,   32'hBFC00000);
        @(negedge clk);
        check("t1_valid_n1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_n2", 32'(instr_valid), 32'd1);
        check("t1_opcode",   32'(opcode),      32'd35);
        check("t1_rs",       32'(rs),          32'd1);
        check("t1_rt",       32'(rt),          32'd2);
        check("t1_imm",      32'(immediate),   32'd4);
        @(posedge clk); #1 instr_ready = 1'b1;
        @(posedge clk); #1 instr_ready = 1'b0;
        waitrequest = 1'b1;

        // 2: three stall cycles, read/address held for four
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_read", 32'(read), 32'd1);
            check("t2_addr", address,   32'hBFC00004);
            @(posedge clk); #1;
            if (k == 2) waitrequest = 1'b0;
        end
        fetch_one(32'hBFC00004, 0);

        // 3: consumer stalls five cycles, no new read
        fetch_one(32'hBFC00008, 5);

        // 4: redirect while the request is stalled; old word dropped
        waitrequest    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00400010;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_addr_hold1", address, 32'hBFC0000C);
        @(posedge clk); #1 waitrequest = 1'b0;
        @(negedge clk);
        check("t4_addr_hold2", address,   32'hBFC0000C);
        check("t4_read_hold",  32'(read), 32'd1);
        @(negedge clk);
        check("t4_resp_noread",  32'(read),        32'd0);
        check("t4_resp_novalid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t4_new_read",    32'(read),        32'd1);
        check("t4_new_addr",    address,          32'h00400010);
        check("t4_killed_none", 32'(instr_valid), 32'd0);
        fetch_one(32'h00400010, 0);

        // 5: misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00400013;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_mis_pulse", 32'(misaligned), 32'd1);
        @(negedge clk);
        check("t5_mis_clear", 32'(misaligned), 32'd0);
        check("t5_read",      32'(read),       32'd1);
        check("t5_addr",      address,         32'h00400010);
        fetch_one(32'h00400010, 0);

        // 6: redirect in HOLD without handshake flushes the held word
        wait_valid();
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00400100;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("t6_flush_valid", 32'(instr_valid), 32'd0);
        check("t6_read",        32'(read),        32'd1);
        check("t6_addr",        address,          32'h00400100);
        fetch_one(32'h00400100, 0);

        // 7: PC wrap from 0xFFFFFFFC
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFC;
        @(posedge clk); #1 redirect_valid = 1'b0;
        fetch_one(32'hFFFFFFFC, 0);
`ifdef FETCH_HALT_ON_ZERO_EN
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t7_halt_read",   32'(read),        32'd0);
            check("t7_halted",      32'(halted),      32'd1);
            check("t7_halt_valid",  32'(instr_valid), 32'd0);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("t7_rst_halted", 32'(halted), 32'd0);
        check("t7_rst_read",   32'(read),   32'd1);
        check("t7_rst_addr",   address,     32'hBFC00000);
`else
        @(negedge clk);
        check("t7_wrap_read",   32'(read),   32'd1);
        check("t7_wrap_addr",   address,     32'h00000000);
        check("t7_wrap_halted", 32'(halted), 32'd0);
        fetch_one(32'h00000000, 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
